// File: rtl/lvds_align_pkg.sv
// Shared types and sizing helpers for the LVDS lane word-alignment controller.
package lvds_align_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_CHECK,
        ST_SLIP,
        ST_WAIT,
        ST_VERIFY,
        ST_NEXT,
        ST_DONE,
        ST_FAIL
    } align_state_t;

    localparam logic [5:0] DEF_TRAIN_WORD = 6'h38;

    // Width of a counter that must hold values 0..max_val inclusive.
    function automatic int unsigned cnt_w(input int unsigned max_val);
        return (max_val == 0) ? 1 : $clog2(max_val + 1);
    endfunction

    function automatic int unsigned idx_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lvds_lane_align_ctrl_lane_word_sel.sv
// Registered lane-word mux plus training-word compare; result lags the index by one cycle.
module lane_word_sel
    import lvds_align_pkg::*;
#(
    parameter int unsigned       NUM_LANES  = 4,
    parameter int unsigned       DATA_W     = 6,
    parameter logic [DATA_W-1:0] TRAIN_WORD = DATA_W'(DEF_TRAIN_WORD),
    parameter int unsigned       IDX_W      = 2
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic [NUM_LANES*DATA_W-1:0] i_lane_data,
    input  logic [IDX_W-1:0]            i_lane_idx,
    output logic                        o_match
);

    logic [DATA_W-1:0] w_words [NUM_LANES];
    logic              r_match;

    always_comb begin
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            w_words[i] = i_lane_data[i*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_match <= 1'b0;
        end else begin
            r_match <= (w_words[i_lane_idx] == TRAIN_WORD);
        end
    end

    assign o_match = r_match;

endmodule

// File: rtl/lvds_lane_align_ctrl.sv
// Word-alignment training FSM: compares each lane against the training word and
// issues ISERDES bitslip pulses one lane at a time until every lane is aligned.
module lvds_lane_align_ctrl
    import lvds_align_pkg::*;
#(
    parameter int unsigned       NUM_LANES  = 4,
    parameter int unsigned       DATA_W     = 6,
    parameter logic [DATA_W-1:0] TRAIN_WORD = DATA_W'(DEF_TRAIN_WORD),
    parameter int unsigned       SETTLE_CYC = 16,
    parameter int unsigned       SLIP_WAIT  = 4,
    parameter int unsigned       MATCH_CYC  = 8
) (
    input  logic                        gclk,
    input  logic                        rst_n,
    input  logic                        pll_reset,
    input  logic                        start,
    input  logic [NUM_LANES*DATA_W-1:0] lane_data,
    output logic [NUM_LANES-1:0]        bitslip,
    output logic                        busy,
    output logic                        done,
    output logic                        fail,
    output logic [NUM_LANES-1:0]        lane_aligned,
    output logic [idx_w(NUM_LANES)-1:0] fail_lane
);

    localparam int unsigned IDX_W   = idx_w(NUM_LANES);
    localparam int unsigned SLIP_W  = cnt_w(DATA_W);
    localparam int unsigned MATCH_W = cnt_w(MATCH_CYC);
    localparam int unsigned TIMER_W = cnt_w(max_u(SETTLE_CYC, SLIP_WAIT));

    localparam logic [IDX_W-1:0]   LAST_IDX    = IDX_W'(NUM_LANES - 1);
    localparam logic [SLIP_W-1:0]  SLIP_LIMIT  = SLIP_W'(DATA_W);
    localparam logic [MATCH_W-1:0] MATCH_GOAL  = MATCH_W'(MATCH_CYC);
    localparam logic [TIMER_W-1:0] SETTLE_LAST = TIMER_W'(SETTLE_CYC - 1);
    localparam logic [TIMER_W-1:0] WAIT_LAST   = TIMER_W'(SLIP_WAIT - 1);

    align_state_t         r_state;
    logic [IDX_W-1:0]     r_lane_idx;
    logic [SLIP_W-1:0]    r_slip_cnt;
    logic [MATCH_W-1:0]   r_match_cnt;
    logic [TIMER_W-1:0]   r_timer;
    logic                 r_pll_prev;
    logic [NUM_LANES-1:0] r_bitslip;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_fail;
    logic [NUM_LANES-1:0] r_lane_aligned;
    logic [IDX_W-1:0]     r_fail_lane;

    logic [IDX_W-1:0]     w_sel_idx;
    logic                 w_match;
    logic [MATCH_W-1:0]   w_match_next;
    logic                 w_start;

    // The compare is registered, so during NEXT the selector already looks at the
    // upcoming lane; the following CHECK then sees that lane's word.
    always_comb begin
        w_sel_idx = r_lane_idx;
        if (r_state == ST_NEXT && r_lane_idx != LAST_IDX) begin
            w_sel_idx = r_lane_idx + IDX_W'(1);
        end
        w_match_next = (r_state == ST_CHECK) ? MATCH_W'(1) : r_match_cnt + MATCH_W'(1);
        w_start      = start | (r_pll_prev & ~pll_reset);
    end

    lane_word_sel #(
        .NUM_LANES  (NUM_LANES),
        .DATA_W     (DATA_W),
        .TRAIN_WORD (TRAIN_WORD),
        .IDX_W      (IDX_W)
    ) u_lane_word_sel (
        .i_clk       (gclk),
        .i_rst_n     (rst_n),
        .i_lane_data (lane_data),
        .i_lane_idx  (w_sel_idx),
        .o_match     (w_match)
    );

    always_ff @(posedge gclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_lane_idx     <= '0;
            r_slip_cnt     <= '0;
            r_match_cnt    <= '0;
            r_timer        <= '0;
            r_pll_prev     <= 1'b0;
            r_bitslip      <= '0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_fail         <= 1'b0;
            r_lane_aligned <= '0;
            r_fail_lane    <= '0;
        end else if (pll_reset) begin
            r_state        <= ST_IDLE;
            r_lane_idx     <= '0;
            r_slip_cnt     <= '0;
            r_match_cnt    <= '0;
            r_timer        <= '0;
            r_pll_prev     <= 1'b1;
            r_bitslip      <= '0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_fail         <= 1'b0;
            r_lane_aligned <= '0;
            r_fail_lane    <= '0;
        end else begin
            r_pll_prev <= 1'b0;
            r_bitslip  <= '0;
            case (r_state)
                ST_IDLE, ST_DONE, ST_FAIL: begin
                    if (w_start) begin
                        r_state        <= ST_SETTLE;
                        r_busy         <= 1'b1;
                        r_done         <= 1'b0;
                        r_fail         <= 1'b0;
                        r_lane_aligned <= '0;
                        r_fail_lane    <= '0;
                        r_lane_idx     <= '0;
                        r_slip_cnt     <= '0;
                        r_match_cnt    <= '0;
                        r_timer        <= '0;
                    end
                end
                ST_SETTLE: begin
                    if (r_timer == SETTLE_LAST) begin
                        r_timer <= '0;
                        r_state <= ST_CHECK;
                    end else begin
                        r_timer <= r_timer + TIMER_W'(1);
                    end
                end
                ST_CHECK, ST_VERIFY: begin
                    if (w_match) begin
                        r_match_cnt <= w_match_next;
                        if (w_match_next == MATCH_GOAL) begin
                            r_lane_aligned[r_lane_idx] <= 1'b1;
                            r_state                    <= ST_NEXT;
                        end else begin
                            r_state <= ST_VERIFY;
                        end
                    end else if (r_slip_cnt == SLIP_LIMIT) begin
                        r_state     <= ST_FAIL;
                        r_busy      <= 1'b0;
                        r_fail      <= 1'b1;
                        r_fail_lane <= r_lane_idx;
                    end else begin
                        r_match_cnt           <= '0;
                        r_bitslip[r_lane_idx] <= 1'b1;
                        r_slip_cnt            <= r_slip_cnt + SLIP_W'(1);
                        r_state               <= ST_SLIP;
                    end
                end
                ST_SLIP: begin
                    r_timer <= '0;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (r_timer == WAIT_LAST) begin
                        r_timer <= '0;
                        r_state <= ST_CHECK;
                    end else begin
                        r_timer <= r_timer + TIMER_W'(1);
                    end
                end
                ST_NEXT: begin
                    if (r_lane_idx == LAST_IDX) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_lane_idx <= r_lane_idx + IDX_W'(1);
                        r_slip_cnt <= '0;
                        r_state    <= ST_CHECK;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bitslip      = r_bitslip;
    assign busy         = r_busy;
    assign done         = r_done;
    assign fail         = r_fail;
    assign lane_aligned = r_lane_aligned;
    assign fail_lane    = r_fail_lane;

endmodule
